// File: rtl/mips_cpu_bus_core_if.sv
// mips_cpu_bus_core_if
//   Avalon-style single-port memory bus between the CPU core and the shared
//   word RAM.
//   address     : byte address, word aligned
//   write/read  : request strobes, never both high
//   waitrequest : slave stall; master holds the request unchanged while high
//   writedata   : store data
//   byteenable  : byte lanes
//   readdata    : read data, valid when read=1 and waitrequest=0
interface mips_cpu_bus_core_if;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (output address, write, read, writedata, byteenable,
                  input  waitrequest, readdata);
  modport slave  (input  address, write, read, writedata, byteenable,
                  output waitrequest, readdata);
endinterface

// File: rtl/mips_cpu_bus_core.sv
// mips_cpu_bus_core
//   Multi-cycle MIPS-I subset CPU on a single Avalon-style bus. Fetches from
//   RESET_VECTOR, executes with branch delay slots, halts when a pending
//   control transfer to address 0 is applied.
//   clk         : clock, rising edge
//   reset       : synchronous, active low
//   active      : high while executing, low once halted
//   register_v0 : continuous copy of GPR $2
//   bus         : master side of mips_cpu_bus_core_if
// Build option:
//   MIPS_CPU_INVALID_HALT_EN - unsupported opcode/funct halts after EXEC;
//   when undefined such instructions execute as NOP.
module mips_cpu_bus_core #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      active,
  output logic [31:0]               register_v0,
  mips_cpu_bus_core_if.master       bus
);

`ifdef MIPS_CPU_INVALID_HALT_EN
  localparam bit INV_HALT = 1'b1;
`else
  localparam bit INV_HALT = 1'b0;
`endif

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        halt_mem_q, halt_mem_d;   // halt once the in-flight MEM access completes
  logic [31:0] addr_q, addr_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic        active_q, active_d;
  logic [31:0] gpr_q [32];

  logic        gpr_we;
  logic [4:0]  gpr_wa;
  logic [31:0] gpr_wd;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh;
  logic [15:0] imm;
  logic [31:0] rs_v, rt_v, sext, zext, seq, ea, tgt, pc_next;
  logic        valid, take, is_lw, is_sw, halt_now;
  logic        dec_we;
  logic [4:0]  dec_wa;
  logic [31:0] dec_wd;

  always_comb begin
    op   = ir_q[31:26];
    rs   = ir_q[25:21];
    rt   = ir_q[20:16];
    rd   = ir_q[15:11];
    sh   = ir_q[10:6];
    fn   = ir_q[5:0];
    imm  = ir_q[15:0];
    rs_v = gpr_q[rs];
    rt_v = gpr_q[rt];
    sext = {{16{imm[15]}}, imm};
    zext = {16'd0, imm};
    seq  = pc_q + 32'd4;
    ea   = rs_v + sext;

    // Decode: result/destination for register-writing ops, control transfer.
    valid  = 1'b1;
    take   = 1'b0;
    tgt    = 32'd0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    dec_we = 1'b1;
    dec_wa = rt;
    dec_wd = 32'd0;
    case (op)
      6'h00: begin
        dec_wa = rd;
        case (fn)
          6'h00: dec_wd = rt_v << sh;
          6'h02: dec_wd = rt_v >> sh;
          6'h03: dec_wd = $signed(rt_v) >>> sh;
          6'h04: dec_wd = rt_v << rs_v[4:0];
          6'h06: dec_wd = rt_v >> rs_v[4:0];
          6'h07: dec_wd = $signed(rt_v) >>> rs_v[4:0];
          6'h08: begin dec_we = 1'b0; take = 1'b1; tgt = rs_v; end
          6'h09: begin take = 1'b1; tgt = rs_v; dec_wd = pc_q + 32'd8; end
          6'h21: dec_wd = rs_v + rt_v;
          6'h23: dec_wd = rs_v - rt_v;
          6'h24: dec_wd = rs_v & rt_v;
          6'h25: dec_wd = rs_v | rt_v;
          6'h26: dec_wd = rs_v ^ rt_v;
          6'h2A: dec_wd = {31'd0, $signed(rs_v) < $signed(rt_v)};
          6'h2B: dec_wd = {31'd0, rs_v < rt_v};
          default: begin dec_we = 1'b0; valid = 1'b0; end
        endcase
      end
      6'h02: begin dec_we = 1'b0; take = 1'b1; tgt = {seq[31:28], ir_q[25:0], 2'b00}; end
      6'h03: begin
        take = 1'b1; tgt = {seq[31:28], ir_q[25:0], 2'b00};
        dec_wa = 5'd31; dec_wd = pc_q + 32'd8;
      end
      6'h04: begin dec_we = 1'b0; take = (rs_v == rt_v); tgt = seq + (sext << 2); end
      6'h05: begin dec_we = 1'b0; take = (rs_v != rt_v); tgt = seq + (sext << 2); end
      6'h09: dec_wd = rs_v + sext;
      6'h0A: dec_wd = {31'd0, $signed(rs_v) < $signed(sext)};
      6'h0C: dec_wd = rs_v & zext;
      6'h0D: dec_wd = rs_v | zext;
      6'h0E: dec_wd = rs_v ^ zext;
      6'h0F: dec_wd = {imm, 16'd0};
      6'h23: begin dec_we = 1'b0; is_lw = 1'b1; end
      6'h2B: begin dec_we = 1'b0; is_sw = 1'b1; end
      default: begin dec_we = 1'b0; valid = 1'b0; end
    endcase

    // A pending target is applied as the delay-slot instruction retires.
    halt_now = pend_vld_q && (pend_tgt_q == 32'd0);
    pc_next  = pend_vld_q ? pend_tgt_q : seq;

    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    halt_mem_d = halt_mem_q;
    addr_d     = addr_q;
    read_d     = read_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    active_d   = active_q;
    gpr_we     = 1'b0;
    gpr_wa     = 5'd0;
    gpr_wd     = 32'd0;

    case (state_q)
      FETCH: begin
        if (!bus.waitrequest) begin
          ir_d    = bus.readdata;
          read_d  = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        gpr_we     = dec_we;
        gpr_wa     = dec_wa;
        gpr_wd     = dec_wd;
        pc_d       = pc_next;
        pend_vld_d = take;
        pend_tgt_d = tgt;
        if (is_lw || is_sw) begin
          state_d    = MEM;
          addr_d     = ea & 32'hFFFF_FFFC;
          read_d     = is_lw;
          write_d    = is_sw;
          wdata_d    = rt_v;
          halt_mem_d = halt_now;
        end else if (halt_now || (INV_HALT && !valid)) begin
          state_d  = HALT;
          read_d   = 1'b0;
          write_d  = 1'b0;
          active_d = 1'b0;
        end else begin
          state_d = FETCH;
          addr_d  = pc_next & 32'hFFFF_FFFC;
          read_d  = 1'b1;
        end
      end
      MEM: begin
        if (!bus.waitrequest) begin
          if (read_q) begin
            gpr_we = 1'b1;
            gpr_wa = rt;
            gpr_wd = bus.readdata;
          end
          write_d = 1'b0;
          if (halt_mem_q) begin
            state_d  = HALT;
            read_d   = 1'b0;
            active_d = 1'b0;
          end else begin
            state_d = FETCH;
            addr_d  = pc_q & 32'hFFFF_FFFC;
            read_d  = 1'b1;
          end
        end
      end
      default: ;  // HALT: frozen until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_VECTOR;
      ir_q       <= 32'd0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= 32'd0;
      halt_mem_q <= 1'b0;
      addr_q     <= RESET_VECTOR;
      read_q     <= 1'b1;
      write_q    <= 1'b0;
      wdata_q    <= 32'd0;
      active_q   <= 1'b1;
      for (int i = 0; i < 32; i++) gpr_q[i] <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      halt_mem_q <= halt_mem_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      active_q   <= active_d;
      // $0 is never written, so it always reads back zero.
      if (gpr_we && (gpr_wa != 5'd0)) gpr_q[gpr_wa] <= gpr_wd;
    end
  end

  assign bus.address    = addr_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.writedata  = wdata_q;
  assign bus.byteenable = 4'b1111;
  assign active         = active_q;
  assign register_v0    = gpr_q[2];

endmodule

// File: tb/tb_mips_cpu_bus_core.sv
module tb_mips_cpu_bus_core;
  logic        clk;
  logic        reset;
  logic        active;
  logic [31:0] v0;

  mips_cpu_bus_core_if bus();

  mips_cpu_bus_core dut (
    .clk        (clk),
    .reset      (reset),
    .active     (active),
    .register_v0(v0),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register numbers
  localparam logic [4:0] ZR = 5'd0, V0 = 5'd2, V1 = 5'd3, T0 = 5'd8, T1 = 5'd9,
    T2 = 5'd10, T3 = 5'd11, T4 = 5'd12, T5 = 5'd13, T6 = 5'd14, T7 = 5'd15,
    S0 = 5'd16, S1 = 5'd17, S2 = 5'd18, S3 = 5'd19, RA = 5'd31;
  // Opcodes / funct codes
  localparam logic [5:0] JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05, ADDIU = 6'h09,
    SLTI = 6'h0A, ANDI = 6'h0C, ORI = 6'h0D, XORI = 6'h0E, LUI = 6'h0F,
    LW = 6'h23, SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03,
    F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08,
    F_JALR = 6'h09, F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24,
    F_OR = 6'h25, F_XOR = 6'h26, F_SLT = 6'h2A, F_SLTU = 6'h2B;

  function automatic logic [31:0] r_op(input logic [4:0] rs, rt, rd, sh,
                                       input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] i_op(input logic [5:0] op,
                                       input logic [4:0] rs, rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] j_op(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  // RAM model: 256 words aliased over the address space, programmable stalls.
  logic [31:0] mem [256];
  int          nwait;
  int          wcnt;
  logic        ld_en;
  logic [7:0]  ld_a;
  logic [31:0] ld_d;

  assign bus.waitrequest = (bus.read | bus.write) && (wcnt < nwait);
  assign bus.readdata    = mem[bus.address[9:2]];

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (reset && bus.write && !bus.waitrequest) mem[bus.address[9:2]] <= bus.writedata;
    if (!reset || !(bus.read | bus.write) || !bus.waitrequest) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  logic        stable_ok, excl_ok;
  int          nwr;
  logic [31:0] wr_data, wr_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ld(input logic [7:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic begin_load(input int nw);
    @(negedge clk);
    reset = 1'b0;
    nwait = nw;
  endtask

  // Reset-state checks while reset is still low, then release.
  task automatic release_reset(input string tag);
    @(negedge clk);
    chk({tag, "_rst_addr"}, bus.address, 32'hBFC0_0000);
    chk({tag, "_rst_read"}, {31'd0, bus.read}, 32'd1);
    chk({tag, "_rst_write"}, {31'd0, bus.write}, 32'd0);
    chk({tag, "_rst_be"}, {28'd0, bus.byteenable}, 32'hF);
    chk({tag, "_rst_active"}, {31'd0, active}, 32'd1);
    chk({tag, "_rst_v0"}, v0, 32'd0);
    reset = 1'b1;
  endtask

  task automatic run_to_halt(input string tag, input int maxc);
    logic [31:0] pa, pd;
    logic        pr, pw, pwt;
    cyc = 0; stable_ok = 1'b1; excl_ok = 1'b1; nwr = 0;
    wr_data = 32'd0; wr_addr = 32'd0;
    while (cyc < maxc) begin
      pwt = bus.waitrequest; pa = bus.address; pr = bus.read;
      pw = bus.write; pd = bus.writedata;
      if (pw && !pwt) begin nwr++; wr_data = pd; wr_addr = pa; end
      @(negedge clk);
      cyc++;
      if (pwt && (bus.address !== pa || bus.read !== pr ||
                  bus.write !== pw || bus.writedata !== pd)) stable_ok = 1'b0;
      if (bus.read && bus.write) excl_ok = 1'b0;
      if (!active) break;
    end
    chk({tag, "_halted"}, {31'd0, active}, 32'd0);
    chk({tag, "_excl"}, {31'd0, excl_ok}, 32'd1);
  endtask

  task automatic check_frozen(input string tag, input logic [31:0] exp_v0);
    repeat (3) @(negedge clk);
    chk({tag, "_hold_read"}, {31'd0, bus.read}, 32'd0);
    chk({tag, "_hold_write"}, {31'd0, bus.write}, 32'd0);
    chk({tag, "_hold_active"}, {31'd0, active}, 32'd0);
    chk({tag, "_hold_v0"}, v0, exp_v0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; ld_en = 1'b0; ld_a = 8'd0; ld_d = 32'd0; nwait = 0;
    repeat (2) @(negedge clk);

    // SRAV: only rs[4:0]=4 used, sign fill from rt[31]
    begin_load(0);
    ld(8'h00, i_op(LUI, ZR, V1, 16'hBFC0));
    ld(8'h01, i_op(LW, V1, T1, 16'h0028));
    ld(8'h02, i_op(LW, V1, T2, 16'h002C));
    ld(8'h03, r_op(ZR, ZR, ZR, ZR, F_JR));
    ld(8'h04, r_op(T2, T1, V0, ZR, F_SRAV));
    ld(8'h0A, 32'h8000_0010);
    ld(8'h0B, 32'h0000_0024);
    release_reset("srav");
    run_to_halt("srav", 300);
    chk("srav_v0", v0, 32'hF800_0001);
    chk("srav_cycles", cyc, 32'd12);
    check_frozen("srav", 32'hF800_0001);

    // Same program, 3 stall cycles on every access
    begin_load(3);
    release_reset("wait");
    run_to_halt("wait", 300);
    chk("wait_v0", v0, 32'hF800_0001);
    chk("wait_cycles", cyc, 32'd33);
    chk("wait_stable", {31'd0, stable_ok}, 32'd1);

    // Store then load back
    begin_load(0);
    ld(8'h00, i_op(ADDIU, ZR, T0, 16'h1234));
    ld(8'h01, i_op(LUI, ZR, V1, 16'hBFC0));
    ld(8'h02, i_op(SW, V1, T0, 16'h0100));
    ld(8'h03, i_op(LW, V1, V0, 16'h0100));
    ld(8'h04, r_op(ZR, ZR, ZR, ZR, F_JR));
    ld(8'h05, 32'd0);
    ld(8'h40, 32'hDEAD_BEEF);
    release_reset("stld");
    run_to_halt("stld", 300);
    chk("stld_v0", v0, 32'h0000_1234);
    chk("stld_cycles", cyc, 32'd14);
    chk("stld_nwrite", nwr, 32'd1);
    chk("stld_wdata", wr_data, 32'h0000_1234);
    chk("stld_waddr", wr_addr, 32'hBFC0_0100);

    // Taken branch: delay slot executes, next instruction skipped
    begin_load(0);
    ld(8'h00, i_op(BEQ, ZR, ZR, 16'h0002));
    ld(8'h01, i_op(ADDIU, V0, V0, 16'h0001));
    ld(8'h02, i_op(ADDIU, V0, V0, 16'h0010));
    ld(8'h03, r_op(ZR, ZR, ZR, ZR, F_JR));
    ld(8'h04, 32'd0);
    release_reset("dslot");
    run_to_halt("dslot", 300);
    chk("dslot_v0", v0, 32'h0000_0001);
    chk("dslot_cycles", cyc, 32'd8);

    // JAL / JALR links are PC+8; JALR to 0 halts after its slot
    begin_load(0);
    ld(8'h00, j_op(JAL, 26'h3F0_0004));
    ld(8'h01, 32'd0);
    ld(8'h02, i_op(ADDIU, ZR, V0, 16'h0055));
    ld(8'h03, 32'd0);
    ld(8'h04, r_op(ZR, ZR, T0, ZR, F_JALR));
    ld(8'h05, r_op(T0, RA, V0, ZR, F_ADDU));
    release_reset("jal");
    run_to_halt("jal", 300);
    chk("jal_v0", v0, 32'h7F80_0020);
    chk("jal_cycles", cyc, 32'd8);

    // ALU mix: compares, shifts, zero-extended logic immediates, untaken BNE
    begin_load(0);
    ld(8'd0,  i_op(ADDIU, ZR, T0, 16'hFFFB));
    ld(8'd1,  i_op(ADDIU, ZR, T1, 16'h0003));
    ld(8'd2,  r_op(T0, T1, T2, ZR, F_SLT));
    ld(8'd3,  r_op(T0, T1, T3, ZR, F_SLTU));
    ld(8'd4,  r_op(ZR, T2, T4, 5'd4, F_SLL));
    ld(8'd5,  r_op(T4, T3, T4, ZR, F_OR));
    ld(8'd6,  r_op(ZR, T0, T5, 5'd28, F_SRL));
    ld(8'd7,  r_op(ZR, T0, T6, 5'd1, F_SRA));
    ld(8'd8,  r_op(T6, T5, T7, ZR, F_SUBU));
    ld(8'd9,  r_op(T7, T4, T7, ZR, F_XOR));
    ld(8'd10, i_op(ANDI, T7, S0, 16'hF0F0));
    ld(8'd11, i_op(ORI, S0, S0, 16'h000F));
    ld(8'd12, i_op(XORI, S0, S0, 16'hFFFF));
    ld(8'd13, r_op(T2, T1, S1, ZR, F_SLLV));
    ld(8'd14, r_op(T1, T0, S2, ZR, F_SRLV));
    ld(8'd15, i_op(SLTI, T0, S3, 16'hFFFC));
    ld(8'd16, i_op(BNE, T3, ZR, 16'h0002));
    ld(8'd17, r_op(S0, S1, V0, ZR, F_ADDU));
    ld(8'd18, r_op(V0, S3, V0, ZR, F_ADDU));
    ld(8'd19, r_op(S2, T7, S2, ZR, F_AND));
    ld(8'd20, r_op(V0, S2, V0, ZR, F_XOR));
    ld(8'd21, r_op(ZR, ZR, ZR, ZR, F_JR));
    ld(8'd22, 32'd0);
    release_reset("alu");
    run_to_halt("alu", 300);
    chk("alu_v0", v0, 32'h1FFF_F0F9);
    chk("alu_cycles", cyc, 32'd46);

    // Reset while SW is stalled in MEM, then rerun to completion
    begin_load(3);
    ld(8'h00, i_op(ADDIU, ZR, T0, 16'h1234));
    ld(8'h01, i_op(LUI, ZR, V1, 16'hBFC0));
    ld(8'h02, i_op(SW, V1, T0, 16'h0100));
    ld(8'h03, i_op(LW, V1, V0, 16'h0100));
    ld(8'h04, r_op(ZR, ZR, ZR, ZR, F_JR));
    ld(8'h05, 32'd0);
    ld(8'h40, 32'hDEAD_BEEF);
    release_reset("mid");
    for (int k = 0; k < 100 && !bus.write; k++) @(negedge clk);
    chk("mid_write_seen", {31'd0, bus.write}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_write_drop", {31'd0, bus.write}, 32'd0);
    chk("mid_read", {31'd0, bus.read}, 32'd1);
    chk("mid_addr", bus.address, 32'hBFC0_0000);
    chk("mid_v0", v0, 32'd0);
    chk("mid_active", {31'd0, active}, 32'd1);
    reset = 1'b1;
    run_to_halt("mid", 300);
    chk("mid_final_v0", v0, 32'h0000_1234);
    chk("mid_nwrite", nwr, 32'd1);
    chk("mid_stable", {31'd0, stable_ok}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
